// File: rtl/max_pooling_layer_if.sv
// -----------------------------------------------------------------------------
// max_pooling_layer_if
// Purpose : bundles the row-stream handshake and result signals of
//           max_pooling_layer so producer and consumer share one typed port.
// Signals :
//   enable               stage enable (low freezes the stage)
//   input_valid          matrix_input_stream carries a valid row this cycle
//   matrix_input_stream  one input row, element 0 at the MSB end
//   matrix_output_stream one pooled row, element 0 at the MSB end
//   output_valid         one-cycle pulse when matrix_output_stream is new
//   is_row_buffered      an even row is held waiting for its partner
//   frame_done           one-cycle pulse after the last row of a frame
// Modports: master drives the row stream (upstream / bench),
//           slave is the pooling stage itself.
// -----------------------------------------------------------------------------
interface max_pooling_layer_if #(
  parameter int data_size              = 4,
  parameter int max_input_matrix_width = 9
);
  localparam int out_width = max_input_matrix_width / 2;

  logic                                        enable;
  logic                                        input_valid;
  logic [data_size*max_input_matrix_width-1:0] matrix_input_stream;
  logic [data_size*out_width-1:0]              matrix_output_stream;
  logic                                        output_valid;
  logic                                        is_row_buffered;
  logic                                        frame_done;

  modport master (
    output enable,
    output input_valid,
    output matrix_input_stream,
    input  matrix_output_stream,
    input  output_valid,
    input  is_row_buffered,
    input  frame_done
  );

  modport slave (
    input  enable,
    input  input_valid,
    input  matrix_input_stream,
    output matrix_output_stream,
    output output_valid,
    output is_row_buffered,
    output frame_done
  );
endinterface

// File: rtl/max_pooling_layer.sv
// -----------------------------------------------------------------------------
// max_pooling_layer
// Purpose : 2x2 / stride-2 max pooling on a row-wise feature-map stream.
//           An even row is buffered, then combined with the next (odd) row
//           to produce one pooled row of max_input_matrix_width/2 elements.
//           Rows are counted per frame; frame_done pulses after the last one.
// Ports   :
//   clk    rising-edge clock
//   reset  synchronous, active-high reset (dominates everything else)
//   bus    max_pooling_layer_if.slave (row stream in, pooled row out, status)
// -----------------------------------------------------------------------------
module max_pooling_layer #(
  parameter int data_size              = 4,
  parameter int max_input_matrix_width = 9,
  parameter int input_matrix_height    = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  max_pooling_layer_if.slave    bus
);

  localparam int out_width = max_input_matrix_width / 2;
  localparam int row_bits  = data_size * max_input_matrix_width;
  // Only the paired columns are ever used; an odd trailing column is dropped.
  localparam int pair_bits = data_size * 2 * out_width;
  localparam int out_bits  = data_size * out_width;
  localparam int cnt_w     = (input_matrix_height > 1) ? $clog2(input_matrix_height) : 1;
  localparam logic [cnt_w-1:0] last_row = cnt_w'(input_matrix_height - 1);

  typedef enum logic {
    WAIT_FIRST  = 1'b0,
    WAIT_SECOND = 1'b1
  } state_t;

  state_t               r_state;
  logic [cnt_w-1:0]     r_row_cnt;
  logic [pair_bits-1:0] r_row_buf;
  logic [out_bits-1:0]  r_out;
  logic                 r_out_valid;
  logic                 r_row_buffered;
  logic                 r_frame_done;

  logic                 w_accept;
  logic                 w_last_row;
  logic [pair_bits-1:0] w_in_pairs;
  logic [out_bits-1:0]  w_pool;

  assign w_accept   = bus.enable & bus.input_valid;
  assign w_last_row = (r_row_cnt == last_row);
  assign w_in_pairs = bus.matrix_input_stream[row_bits-1 -: pair_bits];

  // The trailing odd column never takes part in pooling.
  if ((max_input_matrix_width % 2) != 0) begin : g_odd_tail
    logic w_unused_tail;
    assign w_unused_tail = ^bus.matrix_input_stream[data_size-1:0];
  end

  // One 4-input unsigned max per output column: buffered pair vs. incoming pair.
  for (genvar gi = 0; gi < out_width; gi++) begin : g_pool
    localparam int hi0 = data_size * (2 * out_width - 2 * gi) - 1;
    localparam int hi1 = data_size * (2 * out_width - 2 * gi - 1) - 1;
    localparam int hio = data_size * (out_width - gi) - 1;

    logic [data_size-1:0] w_b0, w_b1, w_i0, w_i1, w_m_buf, w_m_in;

    assign w_b0    = r_row_buf[hi0 -: data_size];
    assign w_b1    = r_row_buf[hi1 -: data_size];
    assign w_i0    = w_in_pairs[hi0 -: data_size];
    assign w_i1    = w_in_pairs[hi1 -: data_size];
    assign w_m_buf = (w_b0 >= w_b1) ? w_b0 : w_b1;
    assign w_m_in  = (w_i0 >= w_i1) ? w_i0 : w_i1;
    assign w_pool[hio -: data_size] = (w_m_buf >= w_m_in) ? w_m_buf : w_m_in;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= WAIT_FIRST;
      r_row_cnt      <= '0;
      r_row_buf      <= '0;
      r_out          <= '0;
      r_out_valid    <= 1'b0;
      r_row_buffered <= 1'b0;
      r_frame_done   <= 1'b0;
    end else begin
      // Pulses default low; r_out holds until the next pooled result.
      r_out_valid  <= 1'b0;
      r_frame_done <= 1'b0;
      if (w_accept) begin
        r_frame_done <= w_last_row;
        r_row_cnt    <= w_last_row ? '0 : r_row_cnt + 1'b1;
        case (r_state)
          WAIT_FIRST: begin
            // An unpaired last row of an odd-height frame is dropped.
            if (!w_last_row) begin
              r_row_buf      <= w_in_pairs;
              r_row_buffered <= 1'b1;
              r_state        <= WAIT_SECOND;
            end
          end
          WAIT_SECOND: begin
            r_out          <= w_pool;
            r_out_valid    <= 1'b1;
            r_row_buffered <= 1'b0;
            r_state        <= WAIT_FIRST;
          end
          default: r_state <= WAIT_FIRST;
        endcase
      end
    end
  end

  assign bus.matrix_output_stream = r_out;
  assign bus.output_valid         = r_out_valid;
  assign bus.is_row_buffered      = r_row_buffered;
  assign bus.frame_done           = r_frame_done;

endmodule

// File: doc/max_pooling_layer.md
Name: max_pooling_layer

Overview:
- Downstream stage of convolution_layer. Consumes its row-wise feature-map stream (one row of max_input_matrix_width elements per accepted beat) and applies 2x2 max pooling with stride 2.
- Buffers the even row, combines it with the following odd row, and emits one pooled row of floor(max_input_matrix_width/2) elements.
- Counts rows per frame and flags frame completion.

Parameters:
- data_size, 4, bits per element (unsigned).
- max_input_matrix_width, 9, elements per input row.
- input_matrix_height, 8, rows per frame (>=1).
- Derived localparam out_width = max_input_matrix_width/2 (floor).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- enable  input  1  stage enable; when low, the stage freezes.
- input_valid  input  1  matrix_input_stream holds a valid row this cycle.
- matrix_input_stream  input  data_size*max_input_matrix_width  input row; element i at [data_size*(max_input_matrix_width-i)-1 -: data_size] (element 0 at MSB).
- matrix_output_stream  output  data_size*out_width  pooled row; same MSB-first element ordering.
- output_valid  output  1  one-cycle pulse when matrix_output_stream is new.
- is_row_buffered  output  1  high while an even row is held waiting for its partner.
- frame_done  output  1  one-cycle pulse after the last row of a frame is accepted.

Behaviour:
- Reset (synchronous, active-high; dominates enable and input_valid):
  - state=WAIT_FIRST, row counter=0, row buffer=0.
  - matrix_output_stream=0, output_valid=0, is_row_buffered=0, frame_done=0.
- Accept condition: enable && input_valid at the rising edge. Nothing else changes state.
- State machine, two states:
  - WAIT_FIRST, on accept, when row counter != input_matrix_height-1: store row in buffer; go to WAIT_SECOND; is_row_buffered=1 from the next cycle.
  - WAIT_FIRST, on accept, when row counter == input_matrix_height-1 (odd height, unpaired last row): discard the row; stay in WAIT_FIRST; no output_valid.
  - WAIT_SECOND, on accept: for k in 0..out_width-1, output element k = max of buffer[2k], buffer[2k+1], in[2k], in[2k+1]. Register the result into matrix_output_stream; pulse output_valid; go to WAIT_FIRST; clear is_row_buffered.
- Latency: output_valid is high in the cycle following the edge that accepted the odd (second) row. Throughput: one accepted row per cycle is supported.
- Width and arithmetic:
  - Comparisons are unsigned and full-width.
  - Ties produce the equal value.
  - If max_input_matrix_width is odd, the last column is ignored.
- Row counter:
  - Increments on every accept and wraps to 0 after accepting row input_matrix_height-1.
  - frame_done pulses in the cycle after that accept, coincident with output_valid when height is even.
- Output hold: matrix_output_stream holds its last value until the next pooled result or reset. output_valid and frame_done are zero in every cycle without a new event.
- enable low:
  - No accept; state, buffer, counter and is_row_buffered are held.
  - output_valid=0 and frame_done=0 (a pulse already scheduled by the prior edge still appears for that one cycle).
- input_valid high with enable low: ignored.
- Reset mid-frame: the buffered row is discarded and the counter returns to 0. The first row accepted after reset is treated as row 0 (even).

Test Plan:
- Reset: assert reset for 2 cycles during activity -> all outputs 0, is_row_buffered=0; next accepted row treated as row 0.
- Basic pooling (defaults): accept row 1 2 3 4 5 6 7 8 9, then row 9 8 7 6 5 4 3 2 1 -> one cycle later output_valid=1, matrix_output_stream=16'h9768; is_row_buffered 1 between the rows, then 0.
- Ties/max values: two rows all F -> output 16'hFFFF; two rows all 0 -> 16'h0000; output_valid single-cycle each time.
- Back-to-back frame (height 8): 8 consecutive valid rows -> output_valid pulses after rows 1, 3, 5, 7; frame_done pulses together with the fourth output_valid; counter wraps to 0.
- Stall: accept row A, hold enable=0 for 3 cycles with input_valid=1 and changing data, then enable=1 with row B -> exactly one output, computed from A and B only; is_row_buffered stays 1 throughout the stall.
- Odd height (input_matrix_height=3): rows R0, R1, R2 -> one output from R0/R1; R2 produces no output_valid; frame_done pulses after R2; next row pairs as row 0.
